// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg -- shared constants and types for the MAC batch arbiter.
//
// Contents:
//   BATCH / OPW / RESW  batch length, operand lane width, result width
//   LANES / VECW        operand packing (4 lanes x 16 bits = 64 bits)
//   CNTW / cntT         7-bit batch counters (hold 0..64 without wrapping)
//   arbState            FSM state encoding
//   ownerIdx()          one-hot grant -> client index
// ---------------------------------------------------------------------------
package mac_pkg;

  localparam int BATCH = 64;
  localparam int OPW   = 16;
  localparam int RESW  = 34;
  localparam int LANES = 4;
  localparam int VECW  = LANES * OPW;
  localparam int CNTW  = 7;

  typedef logic [CNTW-1:0] cntT;

  // Index of the last beat of a batch and the "batch complete" count.
  localparam cntT LAST_IDX = cntT'(BATCH - 1);
  localparam cntT FULL_CNT = cntT'(BATCH);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    FILL,
    WAIT_RD,
    DRAIN
  } arbState;

  // Client index of a one-hot grant: 2'b10 -> 1, anything else -> 0.
  function automatic logic ownerIdx(input logic [1:0] gnt);
    return gnt[1] & ~gnt[0];
  endfunction

endpackage : mac_pkg

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2 -- combinational 2-way round-robin pick.
//
// Ports:
//   req       in  2  request vector, bit i = client i
//   lastOwner in  1  index of the client served most recently
//   grant     out 2  one-hot winner, 0 when nobody requests
//
// A lone requester always wins; on a tie the client that was NOT served
// last wins, so a client holding req continuously cannot starve the other.
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       lastOwner,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default before
    // the case, so no path can leave it unassigned and infer a latch.
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = lastOwner ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule : rr_arb2

// File: rtl/mac_batch_arbiter.sv
// ---------------------------------------------------------------------------
// mac_batch_arbiter -- shares one MAC accelerator between two clients, one
// 64-operation batch at a time.
//
// A batch: arbitrate (IDLE) -> one setup cycle (GRANT) -> stream 64 operand
// pairs from the owner into the accelerator (FILL) -> wait for the
// accelerator buffer to fill and fire one block-read (WAIT_RD) -> forward 64
// dot products back to the owner (DRAIN) -> IDLE.
//
// Ports:
//   CLK, RST_N               clock, asynchronous active-low reset
//   req[1:0]                 per-client batch request
//   gnt[1:0]                 one-hot batch owner, 0 when idle
//   c0_vectA/B, c1_vectA/B   client operands, 4 x 16-bit lanes
//   c_valid[1:0]             per-client operand valid
//   c_ready[1:0]             per-client operand accept (owner only, FILL only)
//   EN_mac / RDY_mac         accelerator MAC handshake
//   mac_vectA/B              owner operands muxed to the accelerator
//   EN_blockRead             one-cycle block-read start
//   RDY_blockRead            accelerator buffer full / readable
//   VALID_memVal/memVal_data readback beat from the accelerator
//   rsp_valid[1:0]           per-client result valid (owner only, DRAIN only)
//   rsp_data                 result data (always driven)
//   rsp_last                 marks the 64th result of the batch
//   busy                     FSM not in IDLE
//   err                      sticky protocol error
// ---------------------------------------------------------------------------
module mac_batch_arbiter
  import mac_pkg::*;
(
  input  logic            CLK,
  input  logic            RST_N,

  input  logic [1:0]      req,
  output logic [1:0]      gnt,

  input  logic [VECW-1:0] c0_vectA,
  input  logic [VECW-1:0] c0_vectB,
  input  logic [VECW-1:0] c1_vectA,
  input  logic [VECW-1:0] c1_vectB,
  input  logic [1:0]      c_valid,
  output logic [1:0]      c_ready,

  output logic            EN_mac,
  input  logic            RDY_mac,
  output logic [VECW-1:0] mac_vectA,
  output logic [VECW-1:0] mac_vectB,

  output logic            EN_blockRead,
  input  logic            RDY_blockRead,
  input  logic            VALID_memVal,
  input  logic [RESW-1:0] memVal_data,

  output logic [1:0]      rsp_valid,
  output logic [RESW-1:0] rsp_data,
  output logic            rsp_last,

  output logic            busy,
  output logic            err
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  arbState    stateQ, stateD;
  logic [1:0] gntQ, gntD;
  cntT        fillCntQ, fillCntD;
  cntT        rspCntQ, rspCntD;
  logic       lastOwnerQ, lastOwnerD;
  logic       errQ, errD;

  logic [1:0] pick;
  logic       owner;

  assign owner = ownerIdx(gntQ);

  rr_arb2 u_rr_arb2 (
    .req       (req),
    .lastOwner (lastOwnerQ),
    .grant     (pick)
  );

  // -------------------------------------------------------------------------
  // Datapath: operands and results pass straight through; only the handshake
  // qualifiers depend on the FSM.
  // -------------------------------------------------------------------------
  assign mac_vectA = owner ? c1_vectA : c0_vectA;
  assign mac_vectB = owner ? c1_vectB : c0_vectB;
  assign rsp_data  = memVal_data;

  assign gnt  = gntQ;
  assign busy = (stateQ != IDLE);
  assign err  = errQ;

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    stateD       = stateQ;
    gntD         = gntQ;
    fillCntD     = fillCntQ;
    rspCntD      = rspCntQ;
    lastOwnerD   = lastOwnerQ;
    c_ready      = 2'b00;
    EN_mac       = 1'b0;
    EN_blockRead = 1'b0;
    rsp_valid    = 2'b00;
    rsp_last     = 1'b0;

    unique case (stateQ)
      IDLE: begin
        // Requests are only looked at here; once granted, the batch runs to
        // completion regardless of what req does.
        if (|req) begin
          gntD   = pick;
          stateD = GRANT;
        end
      end

      GRANT: begin
        fillCntD = '0;
        rspCntD  = '0;
        stateD   = FILL;
      end

      FILL: begin
        c_ready[owner] = RDY_mac;
        EN_mac         = c_valid[owner] & RDY_mac;
        if (EN_mac) begin
          fillCntD = fillCntQ + cntT'(1);
          // Leaving FILL on the 64th accept is what blocks a 65th transfer.
          if (fillCntQ == LAST_IDX) begin
            stateD = WAIT_RD;
          end
        end
      end

      WAIT_RD: begin
        if (RDY_blockRead) begin
          EN_blockRead = 1'b1;
          stateD       = DRAIN;
        end
      end

      DRAIN: begin
        rsp_valid[owner] = VALID_memVal;
        if (VALID_memVal) begin
          rspCntD = rspCntQ + cntT'(1);
          if (rspCntQ == LAST_IDX) begin
            rsp_last   = 1'b1;
            gntD       = 2'b00;
            lastOwnerD = owner;
            stateD     = IDLE;
          end
        end
      end

      default: begin
        stateD = IDLE;
        gntD   = 2'b00;
      end
    endcase
  end

  // Sticky protocol checks: readback data with no drain in progress, or the
  // accelerator claiming a full buffer before all operands were delivered.
  always_comb begin
    errD = errQ;
    if (VALID_memVal && (stateQ != DRAIN)) begin
      errD = 1'b1;
    end
    if (RDY_blockRead && (stateQ == FILL) && (fillCntQ < FULL_CNT)) begin
      errD = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // State register. lastOwner resets to client 1 so client 0 wins the first
  // tie after reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stateQ     <= IDLE;
      gntQ       <= 2'b00;
      fillCntQ   <= '0;
      rspCntQ    <= '0;
      lastOwnerQ <= 1'b1;
      errQ       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples the
      // pre-edge value of the others regardless of statement order.
      stateQ     <= stateD;
      gntQ       <= gntD;
      fillCntQ   <= fillCntD;
      rspCntQ    <= rspCntD;
      lastOwnerQ <= lastOwnerD;
      errQ       <= errD;
    end
  end

endmodule : mac_batch_arbiter

// File: doc/mac_batch_arbiter.md
MAC_BATCH_ARBITER -- requirements
Module: mac_batch_arbiter

Interface
REQ-001 The block SHALL use one clock and a reset that is asynchronous and active-low: CLK (in, 1) is the clock and RST_N (in, 1) is the reset.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- req, in, 2: per-client batch request, bit i = client i.
- gnt, out, 2: one-hot batch owner; 0 when idle.
- c0_vectA / c0_vectB, in, 64: client 0 operands, packed 4x16, lane i = [16i+15:16i].
- c1_vectA / c1_vectB, in, 64: client 1 operands, same packing.
- c_valid, in, 2: per-client operand valid.
- c_ready, out, 2: per-client operand accept.
- EN_mac, out, 1: MAC enable to the accelerator.
- RDY_mac, in, 1: accelerator ready for a MAC.
- mac_vectA / mac_vectB, out, 64: muxed operands, same packing.
- EN_blockRead, out, 1: block-read start pulse.
- RDY_blockRead, in, 1: accelerator buffer full and readable.
- VALID_memVal, in, 1: readback data valid.
- memVal_data, in, 34: readback dot product.
- rsp_valid, out, 2: per-client result valid.
- rsp_data, out, 34: result data.
- rsp_last, out, 1: marks the 64th result.
- busy, out, 1: FSM not in IDLE.
- err, out, 1: sticky protocol error.
REQ-003 Parameters SHALL be BATCH = 64, OPW = 16, RESW = 34.

Function
REQ-004 The FSM SHALL have states IDLE, GRANT, FILL, WAIT_RD and DRAIN.
REQ-005 In IDLE, if any req bit is set, the FSM SHALL register the winner into gnt and move to GRANT; the grant is visible one cycle after req is sampled.
REQ-006 Arbitration SHALL be round-robin: a single requester wins; when both request, the client that is not last_owner wins.
REQ-007 GRANT SHALL last exactly one cycle, clear fill_cnt and rsp_cnt, and then move to FILL.
REQ-008 In FILL:
- c_ready[owner] = RDY_mac.
- EN_mac = c_valid[owner] & RDY_mac.
- mac_vectA/B = owner's operands, passed combinationally.
- A transfer occurs when EN_mac = 1 and increments fill_cnt.
REQ-009 The non-owner's c_ready SHALL be 0 in every state; c_ready and EN_mac SHALL be 0 outside FILL.
REQ-010 When the 64th transfer is accepted (fill_cnt 63 -> 64), the FSM SHALL enter WAIT_RD on the next cycle; no 65th transfer is accepted.
REQ-011 In WAIT_RD, on the first cycle RDY_blockRead = 1, EN_blockRead SHALL pulse high for exactly one cycle and the FSM SHALL move to DRAIN.
REQ-012 In DRAIN:
- rsp_valid[owner] = VALID_memVal.
- rsp_data = memVal_data.
- Each valid beat increments rsp_cnt.
- rsp_last = 1 on the beat where rsp_cnt = 63.
REQ-013 After the rsp_last beat, the FSM SHALL return to IDLE, clear gnt and set last_owner = owner.
REQ-014 Deassertion of req during GRANT, FILL, WAIT_RD or DRAIN SHALL be ignored: a batch is committed once granted.
REQ-015 New requests SHALL be sampled only in IDLE; a client that continues to hold req after its batch SHALL lose a tie to the other client.
REQ-016 err SHALL set and remain set until reset on any of the following:
- VALID_memVal = 1 outside DRAIN.
- RDY_blockRead = 1 while in FILL with fill_cnt < 64.
REQ-017 rsp_valid SHALL be 0 outside DRAIN. rsp_data SHALL be don't-care when rsp_valid = 0 but SHALL still be driven.
REQ-018 Counters SHALL be 7 bits wide and SHALL never wrap within a batch.

Reset
REQ-019 On RST_N = 0, the block SHALL immediately enter IDLE with:
- gnt = 0, c_ready = 0, EN_mac = 0, EN_blockRead = 0.
- rsp_valid = 0, rsp_last = 0, busy = 0, err = 0.
- fill_cnt = 0, rsp_cnt = 0.
- last_owner = 1, so client 0 wins the first tie.
REQ-020 A reset asserted mid-batch SHALL abandon the batch with no further EN_mac, EN_blockRead or rsp_valid; re-synchronising the accelerator is the system's responsibility.

Structure
REQ-021 BATCH, OPW, RESW and the state enum SHALL live in a shared package mac_pkg.
REQ-022 A sub-module rr_arb2 SHALL be used for the 2-way round-robin pick; all other logic is flat.

Verification
REQ-023 Single requester: req = 01, 64 operand beats, with the accelerator model returning results 0..63:
- gnt = 01 one cycle later.
- Exactly 64 EN_mac pulses.
- One EN_blockRead pulse.
- rsp_valid[0] asserted 64 times.
- rsp_last on the beat with data 63.
- gnt = 00 afterwards.
REQ-024 Tie: req = 11 out of reset -> client 0 is served first, then client 1, then client 0 again if both keep requesting.
REQ-025 Backpressure: RDY_mac toggled 1 cycle on / 2 cycles off and c_valid randomised -> exactly 64 transfers, operands in order, no transfer while RDY_mac = 0.
REQ-026 Late readiness: RDY_blockRead delayed 10 cycles after the fill completes -> EN_blockRead is a single pulse in the first cycle RDY_blockRead = 1.
REQ-027 Protocol error: VALID_memVal pulsed while in IDLE -> err = 1 and stays 1 until RST_N is asserted.
REQ-028 Reset mid-batch: RST_N pulsed low at fill_cnt = 30 -> all outputs return to reset values; a following req = 10 yields a fresh 64-beat batch for client 1.
